// File: rtl/ibex_rf_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package ibex_rf_pkg;

   localparam int unsigned RF_MAX_RD_PORTS = 4;
   localparam int unsigned RF_MAX_AW       = 5;

   typedef logic [RF_MAX_AW-1:0] rf_addr_t;

   // Address width: RV32E has 16 registers, RV32I has 32.
   function automatic int unsigned rf_addr_width(input bit rv32e);
      return rv32e ? 32'd4 : 32'd5;
   endfunction

endpackage

// File: rtl/ibex_rf_scoreboard.sv
// Busy vector for outstanding long-latency destinations, claim/release
// arbitration, busy count and write-after-write check for port A.
module ibex_rf_scoreboard
   import ibex_rf_pkg::*;
#(
   parameter  int unsigned AW      = 5,
   localparam int unsigned NumRegs = 1 << AW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_a,
   input  logic [AW-1:0]      waddr_a,
   input  logic               we_b,
   input  logic [AW-1:0]      waddr_b,
   input  logic               claim,
   input  logic [AW-1:0]      claim_addr,
   output logic [NumRegs-1:0] busy,
   output logic               claim_ready,
   output logic               a_block,
   output logic               waw_err,
   output logic [AW:0]        busy_cnt
);

   localparam logic [AW:0] CntMax = (AW+1)'(NumRegs - 1);

   logic [NumRegs-1:0] busy_next;
   logic [AW:0]        cnt_next;
   logic               release_hit;
   logic               set_hit;
   logic               inc;
   logic               dec;

   // Claim acceptance, busy-vector update and count delta.
   always_comb begin
      busy_next   = busy;
      cnt_next    = busy_cnt;
      release_hit = 1'b0;
      set_hit     = 1'b0;
      inc         = 1'b0;
      dec         = 1'b0;
      claim_ready = 1'b0;
      a_block     = 1'b0;

      release_hit = we_b && (waddr_b != '0);
      claim_ready = claim && ((claim_addr == '0) || !busy[claim_addr] ||
                              (we_b && (waddr_b == claim_addr)));
      set_hit     = claim_ready && (claim_addr != '0);
      // busy[0] is never set, so x0 writes are never blocked here.
      a_block     = we_a && busy[waddr_a];

      if (release_hit) busy_next[waddr_b] = 1'b0;
      // A claim in the same cycle as a release of the same register wins.
      if (set_hit) busy_next[claim_addr] = 1'b1;

      inc = set_hit && !busy[claim_addr];
      dec = release_hit && busy[waddr_b] && !(set_hit && (claim_addr == waddr_b));

      if (inc && !dec && (busy_cnt != CntMax)) begin
         cnt_next = busy_cnt + (AW+1)'(1);
      end else if (dec && !inc && (busy_cnt != '0)) begin
         cnt_next = busy_cnt - (AW+1)'(1);
      end
   end

   // Scoreboard state and the one-cycle WAW error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
         waw_err  <= 1'b0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= cnt_next;
         waw_err  <= a_block;
      end
   end

endmodule

// File: rtl/ibex_register_file_sb.sv
// Flip-flop register file with configurable read ports, two write ports,
// optional write bypass and an integrated long-latency scoreboard.
module ibex_register_file_sb
   import ibex_rf_pkg::*;
#(
   parameter  int unsigned DataWidth  = 32,
   parameter  bit          RV32E      = 1'b0,
   parameter  int unsigned NumRdPorts = 2,
   parameter  bit          WrBypass   = 1'b1,
   localparam int unsigned AW         = rf_addr_width(RV32E)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumRdPorts*AW-1:0]        raddr_i,
   output logic [NumRdPorts*DataWidth-1:0] rdata_o,
   output logic [NumRdPorts-1:0]           rbusy_o,
   input  logic [AW-1:0]                   waddr_a_i,
   input  logic [DataWidth-1:0]            wdata_a_i,
   input  logic                            we_a_i,
   input  logic [AW-1:0]                   waddr_b_i,
   input  logic [DataWidth-1:0]            wdata_b_i,
   input  logic                            we_b_i,
   input  logic                            claim_i,
   input  logic [AW-1:0]                   claim_addr_i,
   output logic                            claim_ready_o,
   output logic                            waw_err_o,
   output logic [AW:0]                     busy_cnt_o
);

   localparam int unsigned NumRegs = 1 << AW;
   localparam int unsigned RdPorts = (NumRdPorts > RF_MAX_RD_PORTS) ? RF_MAX_RD_PORTS
                                                                      : NumRdPorts;

   logic [DataWidth-1:0] mem [NumRegs];
   logic [NumRegs-1:0]   busy;
   logic                 a_block;
   logic [AW-1:0]        addr;
   logic [DataWidth-1:0] data;

   ibex_rf_scoreboard #(
      .AW (AW)
   ) u_scoreboard (
      .clk         (clk_i),
      .rst         (rst_i),
      .we_a        (we_a_i),
      .waddr_a     (waddr_a_i),
      .we_b        (we_b_i),
      .waddr_b     (waddr_b_i),
      .claim       (claim_i),
      .claim_addr  (claim_addr_i),
      .busy        (busy),
      .claim_ready (claim_ready_o),
      .a_block     (a_block),
      .waw_err     (waw_err_o),
      .busy_cnt    (busy_cnt_o)
   );

   // Data array; port B is applied last so it wins on an address collision.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NumRegs; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (we_a_i && !a_block && (waddr_a_i != '0)) begin
            mem[waddr_a_i] <= wdata_a_i;
         end
         if (we_b_i && (waddr_b_i != '0)) begin
            mem[waddr_b_i] <= wdata_b_i;
         end
      end
   end

   // Per-port read mux with optional same-cycle bypass and busy lookup.
   always_comb begin
      rdata_o = '0;
      rbusy_o = '0;
      addr    = '0;
      data    = '0;
      for (int unsigned p = 0; p < RdPorts; p++) begin
         addr = raddr_i[p*AW +: AW];
         data = (addr == '0) ? '0 : mem[addr];
         if (WrBypass && (addr != '0)) begin
            if (we_b_i && (waddr_b_i == addr)) begin
               data = wdata_b_i;
            end else if (we_a_i && !a_block && (waddr_a_i == addr)) begin
               data = wdata_a_i;
            end
         end
         rdata_o[p*DataWidth +: DataWidth] = data;
         rbusy_o[p] = busy[addr] && !(WrBypass && we_b_i && (waddr_b_i == addr));
      end
   end

endmodule
